// File: rtl/bcd_counter_pkg.sv
// Shared BCD digit type, digit limits and load-validation helper for bcd_counter_n.
// Purely declarative: no latency, no flow control.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_counter_n_digit.sv
// One BCD digit register: clear > load > step, stepping up or down with wrap 9<->0.
// Latency: q updates 1 cycle after a qualifying edge; at_term is combinational.
// No backpressure: step/ld/clr are sampled every edge.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       dir,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  logic       clr,
  output bcd_digit_t q,
  output logic       at_term
);

  assign at_term = dir ? (q == BCD_MAX) : (q == BCD_MIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= BCD_MIN;
    end else if (clr) begin
      q <= BCD_MIN;
    end else if (ld) begin
      q <= ld_val;
    end else if (step) begin
      if (dir) begin
        q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else begin
        q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// Cascadable DIGITS-digit BCD counter with clear, validated load, tc, wrap and err.
// Latency: count/wrap/err 1 cycle; tc combinational. No backpressure; down-count via BCD_COUNTER_DOWN_EN.
// Priority clr > load > en; a rejected load still blocks the count step that cycle.
module bcd_counter_n
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic                up,
`endif
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                wrap,
  output logic                err
);

  logic              dir;
  logic [DIGITS-1:0] at_term;
  logic [DIGITS-1:0] step_vec;
  logic              all_term;
  logic              ld_ok;
  logic              cnt_en;
  logic              ld_go;

`ifdef BCD_COUNTER_DOWN_EN
  assign dir = up;
`else
  assign dir = 1'b1;
`endif

  always_comb begin
    ld_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(load_val[4*i +: 4])) ld_ok = 1'b0;
    end
  end

  assign cnt_en = en && !clr && !load;
  assign ld_go  = load && !clr && ld_ok;

  // Digit i steps when every lower digit sits at its terminal value.
  always_comb begin
    logic run;
    run      = 1'b1;
    step_vec = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step_vec[i] = cnt_en && run;
      run         = run && at_term[i];
    end
    all_term = run;
  end

  assign tc = en && all_term;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .reset   (reset),
      .step    (step_vec[g]),
      .dir     (dir),
      .ld      (ld_go),
      .ld_val  (load_val[4*g +: 4]),
      .clr     (clr),
      .q       (count[4*g +: 4]),
      .at_term (at_term[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      wrap <= cnt_en && all_term;
      err  <= load && !clr && !ld_ok;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n with DIGITS=3: directed cycles push expectations, a negedge monitor checks them.
module tb_bcd_counter_n;

  localparam int DIGITS = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                en = 1'b0;
  logic                clr = 1'b0;
  logic                load = 1'b0;
  logic [4*DIGITS-1:0] load_val = '0;
`ifdef BCD_COUNTER_DOWN_EN
  logic                up = 1'b1;
`endif
  logic [4*DIGITS-1:0] count;
  logic                tc;
  logic                wrap;
  logic                err;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    int          idx;
    logic        dir;
    logic [11:0] cnt;
    logic        tc;
    logic        wrap;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
`ifdef BCD_COUNTER_DOWN_EN
    .up       (up),
`endif
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .err      (err)
  );

  // One clock cycle: drive inputs just after the edge, expect the outputs seen in this cycle.
  task automatic cyc(input logic r, input logic c, input logic l, input logic e, input logic u,
                     input logic [11:0] lv, input logic [11:0] xc,
                     input logic xt, input logic xw, input logic xe);
    exp_t x;
    @(posedge clk);
    #2;
    reset    = r;
    clr      = c;
    load     = l;
    en       = e;
    load_val = lv;
`ifdef BCD_COUNTER_DOWN_EN
    up       = u;
`endif
    step_no++;
    x.idx  = step_no;
    x.dir  = u;
    x.cnt  = xc;
    x.tc   = xt;
    x.wrap = xw;
    x.err  = xe;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if (count !== x.cnt) begin
        errors++;
        $display("FAIL count step %0d up=%0b: got %h expected %h", x.idx, x.dir, count, x.cnt);
      end
      checks++;
      if (tc !== x.tc) begin
        errors++;
        $display("FAIL tc step %0d up=%0b: got %b expected %b", x.idx, x.dir, tc, x.tc);
      end
      checks++;
      if (wrap !== x.wrap) begin
        errors++;
        $display("FAIL wrap step %0d up=%0b: got %b expected %b", x.idx, x.dir, wrap, x.wrap);
      end
      checks++;
      if (err !== x.err) begin
        errors++;
        $display("FAIL err step %0d up=%0b: got %b expected %b", x.idx, x.dir, err, x.err);
      end
    end
  end

  initial begin
    //   rst clr ld  en  up  load_val  count    tc   wrap err
    // reset state, then reset mid-count at 457
    cyc(1, 0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 12'h455, 12'h000, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 12'h000, 12'h455, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 12'h000, 12'h456, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 12'h000, 12'h457, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 12'h000, 12'h000, 0, 0, 0);
    // up carry chain from 098
    cyc(0, 0, 1, 0, 1, 12'h098, 12'h000, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 12'h000, 12'h098, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 12'h000, 12'h099, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 12'h000, 12'h100, 0, 0, 0);
    // up wrap from 998
    cyc(0, 0, 1, 0, 1, 12'h998, 12'h101, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 12'h000, 12'h998, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 12'h000, 12'h999, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 12'h000, 12'h000, 0, 1, 0);
    // invalid loads at 250, including one combined with en
    cyc(0, 0, 1, 0, 1, 12'h250, 12'h000, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 12'h1A3, 12'h250, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 12'h000, 12'h250, 0, 0, 1);
    cyc(0, 0, 1, 1, 1, 12'h25B, 12'h250, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 12'h000, 12'h250, 0, 0, 1);
    // priority: clr beats load and en; load beats en
    cyc(0, 0, 1, 0, 1, 12'h500, 12'h250, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 12'h123, 12'h500, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 12'h123, 12'h000, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 12'h999, 12'h123, 0, 0, 0);
    // load or clr at terminal with en never reports a wrap
    cyc(0, 0, 1, 1, 1, 12'h000, 12'h999, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 12'h999, 12'h000, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 12'h000, 12'h999, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0);
`ifdef BCD_COUNTER_DOWN_EN
    // down count from 001, wrap to 999, then up wraps back to 000
    cyc(0, 0, 1, 0, 0, 12'h001, 12'h000, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 12'h000, 12'h001, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 12'h000, 12'h000, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 12'h000, 12'h999, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 12'h000, 12'h000, 0, 1, 0);
    // down borrow chain from 100
    cyc(0, 0, 1, 0, 0, 12'h100, 12'h000, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 12'h000, 12'h100, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 12'h000, 12'h099, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 12'h000, 12'h098, 0, 0, 0);
`endif
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised multi-digit BCD counter, the next-generation counter for the Counter library. It counts `DIGITS` decimal digits with count enable, synchronous clear, parallel load with BCD validation, and a cascadable terminal-count output. A compile-time option adds down-counting. It drives display and timebase logic directly and chains into further `bcd_counter_n` instances through `tc`.

## Interface
- `DIGITS`, default 4: number of BCD digits, legal range 1..8.
- `clk`  in  1: clock, rising-edge active.
- `reset`  in  1: asynchronous, active-high.
- `en`  in  1: count enable; one step per rising edge while high.
- `clr`  in  1: synchronous clear to zero.
- `load`  in  1: synchronous parallel load from `load_val`.
- `load_val`  in  4*DIGITS: load value; digit i occupies bits [4i+3:4i], LSD at bits [3:0].
- `up`  in  1: direction, 1 = up, 0 = down. Present only when `BCD_COUNTER_DOWN_EN` is defined.
- `count`  out  4*DIGITS: current value, same digit packing as `load_val`.
- `tc`  out  1: combinational terminal count, `en` AND count at terminal value.
- `wrap`  out  1: registered pulse, high for the one cycle after a wrap edge.
- `err`  out  1: registered pulse, high for the one cycle after a rejected load.

## Operation
- Reset: `count` = 0, `wrap` = 0, `err` = 0, effective immediately and held while `reset` is high. Reset mid-count discards the value and has no pending effects.
- Priority on each rising edge is `clr` > `load` > `en`. Lower-priority requests in the same cycle are dropped, not queued.
- `clr`: `count` becomes 0. It never sets `wrap` or `err`.
- `load`:
  - If every digit of `load_val` is 0..9, `count` becomes `load_val`.
  - If any digit is 10..15, the whole load is rejected: `count` holds and `err` pulses.
  - A load never sets `wrap`, even when it is combined with `en`.
- Count up with `en`:
  - Digit i steps when all lower digits are 9.
  - A stepping digit at 9 becomes 0; otherwise it increments.
- Count down with `en` (macro only):
  - Digit i steps when all lower digits are 0.
  - A stepping digit at 0 becomes 9; otherwise it decrements.
- Terminal value is all 9s when counting up and all 0s when counting down.
- Wrap:
  - An enabled step from the terminal value wraps: up goes 9…9 → 0…0, down goes 0…0 → 9…9.
  - `wrap` is high in exactly the cycle in which `count` shows the wrapped value.
- `tc` depends only on the current `count`, `en` and `up`. Cascade by tying the next stage's `en` to this stage's `tc`, so the chain steps on the same edge.
- Non-BCD values are never reachable in `count`.

## Timing
- `count`, `wrap` and `err` are registered, with 1-cycle latency from a qualifying edge.
- `tc` is combinational, with no register stage. A cascade of N stages forms a single combinational enable chain.
- A change of `up` takes effect on the next enabled edge. `tc` re-evaluates in the same cycle as the change.
- `wrap` and `err` are mutually exclusive in any given cycle.
- `wrap` is high for one cycle per wrap. It stays low on non-wrapping cycles even when `en` is held high continuously.

## Configuration
- `BCD_COUNTER_DOWN_EN` defined:
  - The `up` port exists and down-counting is supported.
  - The terminal value for `tc` and `wrap` follows `up`.
- `BCD_COUNTER_DOWN_EN` undefined:
  - There is no `up` port and the block counts up only.
  - The terminal value is fixed at all 9s and no down logic is synthesised.

## Structure
- Package `bcd_counter_pkg` holds:
  - typedef `bcd_digit_t` (4-bit);
  - constants `BCD_MAX` = 9 and `BCD_MIN` = 0;
  - function `is_bcd(bcd_digit_t)` for load validation.
- Sub-module `bcd_digit` implements one digit:
  - inputs `step`, `dir`, `ld`, `ld_val`, `clr`;
  - output `q`;
  - output `at_term`, high when the digit is 9 (up) or 0 (down).
- The top level generates `DIGITS` instances of `bcd_digit`, an AND-chain of `at_term` for the step enables, load validation, and the `wrap`/`err` registers.

## Test plan
All scenarios use `DIGITS` = 3.
- Reset check: assert `reset` mid-count at 457 → `count` = 000 immediately, with `wrap` = 0 and `err` = 0.
- Up carry chain: load 098, then `en` for 3 cycles → `count` = 099, 100, 101, with `tc` low throughout.
- Up wrap: load 998, then `en` → 999 with `tc` = 1, then 000 with `wrap` = 1 for exactly one cycle.
- Invalid load: `load_val` = 0x1A3 while `count` = 250 → `count` stays 250 and `err` = 1 for one cycle.
- Priority: `clr`, `load` (123) and `en` all high at `count` = 500 → `count` = 000. Then `load` + `en` with 123 → `count` = 123.
- With `BCD_COUNTER_DOWN_EN`, `up` = 0: load 001, then `en` → 000 with `tc` = 1, then 999 with `wrap` = 1. Then switch `up` = 1 and apply `en` → 000.
